// File: rtl/acc_bank_pkg.sv
// Shared opcodes and FSM encoding for the accumulator bank.
package acc_bank_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/acc_bank_mac_mul.sv
// Iterative shift-add multiplier for the accumulator bank: one step per cycle,
// WIDTH steps per product, result truncated to WIDTH bits.
module acc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_acc,
    input  logic             rst_acc,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] count;
    logic             running;

    // done marks the cycle whose closing edge performs the final step, so
    // product is complete from the following cycle on.
    assign done = running && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_acc or posedge rst_acc) begin
        if (rst_acc) begin
            a_q     <= '0;
            b_q     <= '0;
            count   <= '0;
            running <= 1'b0;
            product <= '0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            count   <= '0;
            running <= 1'b1;
            product <= '0;
        end else if (running) begin
            if (b_q[0]) begin
                product <= product + a_q;
            end
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            count <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acc_bank_mac.sv
// Bank of NUM_ACC accumulators with single-cycle ALU ops and a sequential multiply.
// Optional macro SATURATE_EN: signed saturating ADD/SUB instead of wrapping.
module acc_bank_mac
    import acc_bank_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    parameter int SEL_W   = $clog2(NUM_ACC)
) (
    input  logic             clk_acc,
    input  logic             rst_acc,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [SEL_W-1:0] acc_sel,
    input  logic [WIDTH-1:0] operand,
    output logic             res_valid,
    output logic [SEL_W-1:0] res_sel,
    output logic [WIDTH-1:0] res_data,
    output logic             zero,
    output logic             positive,
    output logic             carry,
    output logic             busy
);

`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc [NUM_ACC];
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] op_data;
    logic             op_wr;
    logic             op_carry;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign mul_start = accept && (op_code == OP_MUL);
    assign a_val     = acc[acc_sel];

    acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk_acc (clk_acc),
        .rst_acc (rst_acc),
        .start   (mul_start),
        .a       (a_val),
        .b       (operand),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        add_ext = {1'b0, a_val} + {1'b0, operand};
        sub_ext = {1'b0, a_val} - {1'b0, operand};
        add_res = add_ext[WIDTH-1:0];
        sub_res = sub_ext[WIDTH-1:0];
`ifdef SATURATE_EN
        // Signed overflow clamps toward the sign of A; carry stays unsigned.
        if ((a_val[WIDTH-1] == operand[WIDTH-1]) && (add_res[WIDTH-1] != a_val[WIDTH-1])) begin
            add_res = a_val[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        if ((a_val[WIDTH-1] != operand[WIDTH-1]) && (sub_res[WIDTH-1] != a_val[WIDTH-1])) begin
            sub_res = a_val[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        op_data  = a_val;
        op_wr    = 1'b1;
        op_carry = 1'b0;
        case (op_code)
            OP_NOP: begin
                op_wr    = 1'b0;
                op_carry = carry;
            end
            OP_LOAD: op_data = operand;
            OP_ADD: begin
                op_data  = add_res;
                op_carry = add_ext[WIDTH];
            end
            OP_SUB: begin
                op_data  = sub_res;
                op_carry = sub_ext[WIDTH];
            end
            OP_AND:  op_data = a_val & operand;
            OP_OR:   op_data = a_val | operand;
            OP_CLR:  op_data = '0;
            default: op_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_acc or posedge rst_acc) begin
        if (rst_acc) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_acc or posedge rst_acc) begin
        if (rst_acc) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
            sel_q     <= '0;
            res_valid <= 1'b0;
            res_sel   <= '0;
            res_data  <= '0;
            zero      <= 1'b1;
            positive  <= 1'b1;
            carry     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (accept) begin
                if (op_code == OP_MUL) begin
                    sel_q <= acc_sel;
                end else begin
                    if (op_wr) begin
                        acc[acc_sel] <= op_data;
                    end
                    res_valid <= 1'b1;
                    res_sel   <= acc_sel;
                    res_data  <= op_data;
                    zero      <= (op_data == '0);
                    positive  <= ~op_data[WIDTH-1];
                    carry     <= op_carry;
                end
            end else if (state == ST_WB) begin
                acc[sel_q] <= mul_product;
                res_valid  <= 1'b1;
                res_sel    <= sel_q;
                res_data   <= mul_product;
                zero       <= (mul_product == '0);
                positive   <= ~mul_product[WIDTH-1];
                carry      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_bank_mac.sv
// Self-checking bench for acc_bank_mac: table-driven single-cycle ops plus
// hand-written multiply, abort, reset and back-to-back sequences.
module tb_acc_bank_mac;
    import acc_bank_pkg::*;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       z;
        logic       p;
        logic       c;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] sel;
        logic [7:0] opd;
        exp_t       exp;
    } vec_t;

    logic       clk_acc = 1'b0;
    logic       rst_acc = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_code = '0;
    logic [1:0] acc_sel = '0;
    logic [7:0] operand = '0;
    logic       res_valid;
    logic [1:0] res_sel;
    logic [7:0] res_data;
    logic       zero;
    logic       positive;
    logic       carry;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    int   rv_run = 0;
    int   rv_run_max = 0;
    exp_t exp_q[$];
    vec_t vecs[13];

    acc_bank_mac #(.WIDTH(8), .NUM_ACC(4)) dut (
        .clk_acc   (clk_acc),
        .rst_acc   (rst_acc),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .acc_sel   (acc_sel),
        .operand   (operand),
        .res_valid (res_valid),
        .res_sel   (res_sel),
        .res_data  (res_data),
        .zero      (zero),
        .positive  (positive),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk_acc = ~clk_acc;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(logic [1:0] s, logic [7:0] d, logic z, logic p, logic c);
        exp_t e;
        e.sel = s; e.data = d; e.z = z; e.p = p; e.c = c;
        return e;
    endfunction

    function automatic vec_t mkVec(logic [2:0] op, logic [1:0] s, logic [7:0] opd,
                                   logic [7:0] d, logic z, logic p, logic c);
        vec_t v;
        v.op = op; v.sel = s; v.opd = opd; v.exp = mkExp(s, d, z, p, c);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drives one command at a falling edge; it is accepted at the next rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] s, input logic [7:0] opd,
                                 input bit push, input exp_t e);
        @(negedge clk_acc);
        checkOutput("ready_at_issue", {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1;
        op_code  = op;
        acc_sel  = s;
        operand  = opd;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_acc);
            op_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk_acc);
            #1;
            n++;
        end
        checkOutput("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    // Scoreboard: every result pulse must match the oldest expected entry.
    always @(negedge clk_acc) begin
        if (!rst_acc) begin
            if (res_valid) begin
                rv_run++;
                if (rv_run > rv_run_max) rv_run_max = rv_run;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got sel=%0d data=%0h expected no pulse", res_sel, res_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result", {19'd0, res_sel, res_data, zero, positive, carry}, {19'd0, e});
                end
            end else begin
                rv_run = 0;
            end
        end
    end

    initial begin
        int not_ready;

        vecs[0]  = mkVec(OP_LOAD, 2'd2, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0);
`ifdef SATURATE_EN
        vecs[1]  = mkVec(OP_ADD,  2'd2, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
`else
        vecs[1]  = mkVec(OP_ADD,  2'd2, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
`endif
        vecs[2]  = mkVec(OP_LOAD, 2'd1, 8'h03, 8'h03, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mkVec(OP_SUB,  2'd1, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mkVec(OP_ADD,  2'd1, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1);
        vecs[5]  = mkVec(OP_NOP,  2'd1, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b1);
        vecs[6]  = mkVec(OP_LOAD, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mkVec(OP_AND,  2'd0, 8'h3C, 8'h30, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mkVec(OP_OR,   2'd0, 8'h0F, 8'h3F, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mkVec(OP_CLR,  2'd0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        vecs[10] = mkVec(OP_LOAD, 2'd1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
`ifdef SATURATE_EN
        vecs[11] = mkVec(OP_SUB,  2'd1, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0);
        vecs[12] = mkVec(OP_NOP,  2'd2, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0);
`else
        vecs[11] = mkVec(OP_SUB,  2'd1, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        vecs[12] = mkVec(OP_NOP,  2'd2, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
`endif

        // Power-on reset values.
        repeat (2) @(negedge clk_acc);
        checkOutput("rst_op_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_flags_zpc", {29'd0, zero, positive, carry}, 32'h6);
        checkOutput("rst_res_data", {24'd0, res_data}, 32'd0);
        rst_acc = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].sel, vecs[i].opd, 1'b1, vecs[i].exp);
            idle(1);
        end
        drain();

        // Multiply 0x0C * 0x0B into acc3 with a competing command held on op_valid.
        applyStimulus(OP_LOAD, 2'd3, 8'h0C, 1'b1, mkExp(2'd3, 8'h0C, 1'b0, 1'b1, 1'b0));
        idle(1);
        drain();
        applyStimulus(OP_MUL, 2'd3, 8'h0B, 1'b1, mkExp(2'd3, 8'h84, 1'b0, 1'b0, 1'b0));
        not_ready = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk_acc);
            if (i == 1) begin
                op_code = OP_LOAD;
                acc_sel = 2'd0;
                operand = 8'h55;
            end
            if (!op_ready && busy) not_ready++;
            checkOutput("mul_no_early_result", {31'd0, res_valid}, 32'd0);
        end
        op_valid = 1'b0;
        @(negedge clk_acc);
        checkOutput("mul_result_at_cycle9", {31'd0, res_valid}, 32'd1);
        checkOutput("mul_not_ready_cycles", not_ready, 32'd9);
        checkOutput("mul_ready_after_wb", {30'd0, op_ready, busy}, 32'h2);
        drain();
        applyStimulus(OP_NOP, 2'd0, 8'h00, 1'b1, mkExp(2'd0, 8'h00, 1'b1, 1'b1, 1'b0));
        idle(1);
        drain();

        // Wrapping multiply: 0x20 * 0x10 = 0x200.
        applyStimulus(OP_LOAD, 2'd0, 8'h20, 1'b1, mkExp(2'd0, 8'h20, 1'b0, 1'b1, 1'b0));
        applyStimulus(OP_MUL, 2'd0, 8'h10, 1'b1, mkExp(2'd0, 8'h00, 1'b1, 1'b1, 1'b0));
        idle(1);
        drain();

        // Back-to-back accepts.
        rv_run_max = 0;
        applyStimulus(OP_LOAD, 2'd0, 8'h01, 1'b1, mkExp(2'd0, 8'h01, 1'b0, 1'b1, 1'b0));
        applyStimulus(OP_LOAD, 2'd1, 8'h02, 1'b1, mkExp(2'd1, 8'h02, 1'b0, 1'b1, 1'b0));
        applyStimulus(OP_ADD, 2'd0, 8'h05, 1'b1, mkExp(2'd0, 8'h06, 1'b0, 1'b1, 1'b0));
        idle(2);
        drain();
        checkOutput("b2b_consecutive_valid", rv_run_max, 32'd3);

        // Asynchronous reset pulse in the middle of a cycle.
        @(posedge clk_acc);
        #2 rst_acc = 1'b1;
        #1;
        checkOutput("arst_op_ready_busy", {30'd0, op_ready, busy}, 32'h2);
        checkOutput("arst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("arst_flags_zpc", {29'd0, zero, positive, carry}, 32'h6);
        checkOutput("arst_res_data", {24'd0, res_data}, 32'd0);
        @(negedge clk_acc);
        rst_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_NOP, 2'(i), 8'h00, 1'b1, mkExp(2'(i), 8'h00, 1'b1, 1'b1, 1'b0));
        end
        idle(1);
        drain();

        // Reset during multiply step 4 aborts without any write.
        applyStimulus(OP_LOAD, 2'd3, 8'h0C, 1'b1, mkExp(2'd3, 8'h0C, 1'b0, 1'b1, 1'b0));
        idle(1);
        drain();
        applyStimulus(OP_MUL, 2'd3, 8'h0B, 1'b0, mkExp(2'd3, 8'h00, 1'b0, 1'b0, 1'b0));
        idle(1);
        repeat (3) @(negedge clk_acc);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        #1 rst_acc = 1'b1;
        #1;
        checkOutput("abort_ready_busy", {30'd0, op_ready, busy}, 32'h2);
        checkOutput("abort_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk_acc);
        rst_acc = 1'b0;
        idle(14);
        applyStimulus(OP_NOP, 2'd3, 8'h00, 1'b1, mkExp(2'd3, 8'h00, 1'b1, 1'b1, 1'b0));
        idle(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
